// File: rtl/morse_decoder_if.sv
// Morse line in, decoded letter/status out; master drives the line, slave is the decoder.
interface morse_decoder_if;
  logic       morse_in;
  logic [2:0] letter;
  logic       valid;
  logic       err;
  logic [3:0] LEDR;

  modport master (output morse_in, input letter, valid, err, LEDR);
  modport slave  (input morse_in, output letter, valid, err, LEDR);
endinterface

// File: rtl/morse_decoder.sv
// Morse decoder for letters A..H, runs timed in UNIT_CYC clocks; `define MORSE_DEC_ERR_EN drives err.
// valid lands 2*UNIT_CYC+3 clocks after the last mark falls; no backpressure, valid/err are 1-cycle pulses.
module morse_decoder #(
  parameter int unsigned UNIT_CYC = 33554432
) (
  input  logic           CLOCK_50,
  input  logic [1:0]     KEY,
  morse_decoder_if.slave bus
);

`ifdef MORSE_DEC_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam logic [27:0] HALF = 28'(UNIT_CYC / 2);
  localparam logic [27:0] TWO  = 28'(2 * UNIT_CYC);
  localparam logic [27:0] FOUR = 28'(4 * UNIT_CYC);

  typedef enum logic [1:0] {IDLE, MARK, SPACE, DRAIN} state_t;

  state_t      r_state, w_state_n;
  logic        r_s1, r_s, r_s_prev;
  logic [27:0] r_run;
  logic [3:0]  r_sym, w_sym_n;
  logic [2:0]  r_nsym, w_nsym_n;
  logic [2:0]  r_letter, w_dec_code;
  logic        r_valid, r_err, r_hold;
  logic        w_dec_vld, w_err_evt, w_dec_hit;

  // r_run is the length of the run that s had in the previous cycle
  always_ff @(posedge CLOCK_50) begin
    if (!KEY[0]) begin
      r_s1     <= 1'b0;
      r_s      <= 1'b0;
      r_s_prev <= 1'b0;
      r_run    <= '0;
    end else begin
      r_s1     <= bus.morse_in;
      r_s      <= r_s1;
      r_s_prev <= r_s;
      if (r_s != r_s_prev)
        r_run <= 28'd1;
      else if (r_run != '1)
        r_run <= r_run + 28'd1;
    end
  end

  always_comb begin
    w_dec_hit  = 1'b1;
    w_dec_code = 3'd0;
    case ({r_nsym, r_sym})
      {3'd2, 4'b0001}: w_dec_code = 3'd0;
      {3'd4, 4'b1000}: w_dec_code = 3'd1;
      {3'd4, 4'b1010}: w_dec_code = 3'd2;
      {3'd3, 4'b0100}: w_dec_code = 3'd3;
      {3'd1, 4'b0000}: w_dec_code = 3'd4;
      {3'd4, 4'b0010}: w_dec_code = 3'd5;
      {3'd3, 4'b0110}: w_dec_code = 3'd6;
      {3'd4, 4'b0000}: w_dec_code = 3'd7;
      default:         w_dec_hit  = 1'b0;
    endcase
  end

  always_comb begin
    w_state_n = r_state;
    w_sym_n   = r_sym;
    w_nsym_n  = r_nsym;
    w_dec_vld = 1'b0;
    w_err_evt = 1'b0;
    unique case (r_state)
      IDLE: if (r_s) w_state_n = MARK;
      MARK: if (!r_s) begin
        if (r_run < HALF) begin
          w_state_n = (r_nsym == 3'd0) ? IDLE : SPACE;
        end else if (r_run > FOUR || r_nsym == 3'd4) begin
          w_state_n = DRAIN;
          w_err_evt = 1'b1;
        end else begin
          w_sym_n   = {r_sym[2:0], (r_run >= TWO)};
          w_nsym_n  = r_nsym + 3'd1;
          w_state_n = SPACE;
        end
      end
      // the letter gap completing takes priority over a mark that starts right at its end
      SPACE: if (r_run == TWO) begin
        w_state_n = IDLE;
        w_dec_vld = w_dec_hit;
        w_err_evt = !w_dec_hit;
      end else if (r_s) begin
        w_state_n = MARK;
      end
      DRAIN: if (!r_s_prev && r_run >= TWO) w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
    if (w_state_n == IDLE) begin
      w_sym_n  = '0;
      w_nsym_n = '0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!KEY[0]) begin
      r_state  <= IDLE;
      r_sym    <= '0;
      r_nsym   <= '0;
      r_letter <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_hold   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_sym   <= w_sym_n;
      r_nsym  <= w_nsym_n;
      r_valid <= w_dec_vld;
      r_err   <= w_err_evt & ERR_EN;
      if (w_dec_vld)
        r_letter <= w_dec_code;
      if (w_dec_vld)
        r_hold <= 1'b1;
      else if (!KEY[1])
        r_hold <= 1'b0;
    end
  end

  assign bus.letter = r_letter;
  assign bus.valid  = r_valid;
  assign bus.err    = r_err;
  assign bus.LEDR   = {r_hold, r_letter};

endmodule

// File: tb/tb_morse_decoder.sv
// Randomized bench for morse_decoder: a symbol-level model predicts each letter's event into a scoreboard.
module tb_morse_decoder;

`ifdef MORSE_DEC_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam int U = 8;

  typedef struct {
    bit         is_err;
    logic [2:0] letter;
    int         at;
  } exp_t;

  logic       clk = 1'b0;
  logic [1:0] key;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  logic [2:0] mon_letter = 3'd0;
  exp_t       exp_q[$];
  int         mk[$];
  int         sp[$];
  string      tbl[8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};

  morse_decoder_if bus();

  morse_decoder #(.UNIT_CYC(U)) dut (
    .CLOCK_50(clk),
    .KEY     (key),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic void push(input bit is_err, input logic [2:0] l, input int at);
    exp_t e;
    e.is_err = is_err;
    e.letter = l;
    e.at     = at;
    exp_q.push_back(e);
  endfunction

  task automatic hold(input logic lvl, input int n);
    bus.morse_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  // Model: classify each mark by length, spell the letter, look it up in the Morse table.
  task automatic send(input bit ack);
    string code;
    bit    bad;
    int    t;
    int    idx;
    code = "";
    bad  = 1'b0;
    for (int i = 0; i < mk.size(); i++) begin
      hold(1'b1, mk[i]);
      t = cyc;
      if (!bad && mk[i] >= U / 2) begin
        if (mk[i] > 4 * U || code.len() == 4) begin
          bad = 1'b1;
          if (ERR_EN) push(1'b1, 3'd0, t + 3);
        end else if (mk[i] >= 2 * U) begin
          code = {code, "-"};
        end else begin
          code = {code, "."};
        end
      end
      if (i == mk.size() - 1 && !bad && code.len() > 0) begin
        idx = -1;
        for (int j = 0; j < 8; j++)
          if (code == tbl[j]) idx = j;
        if (idx >= 0) push(1'b0, 3'(idx), t + 2 * U + 3);
        else if (ERR_EN) push(1'b1, 3'd0, t + 2 * U + 3);
      end
      if (ack && i == mk.size() - 1) begin
        hold(1'b0, 2 * U + 2);
        key[1] = 1'b0;
        hold(1'b0, 1);
        key[1] = 1'b1;
        hold(1'b0, sp[i] - 2 * U - 3);
      end else begin
        hold(1'b0, sp[i]);
      end
    end
  endtask

  task automatic build_random();
    string c;
    int    kind;
    int    n;
    mk.delete();
    sp.delete();
    kind = int'($urandom_range(0, 9));
    if (kind < 6) begin
      c = tbl[$urandom_range(0, 7)];
    end else begin
      c = "";
      n = int'($urandom_range(1, 5));
      repeat (n) begin
        if ($urandom_range(0, 1) == 1) c = {c, "-"};
        else c = {c, "."};
      end
    end
    for (int i = 0; i < c.len(); i++) begin
      if (c[i] == "-") mk.push_back(int'($urandom_range(16, 32)));
      else mk.push_back(int'($urandom_range(4, 15)));
      if (i == c.len() - 1) begin
        sp.push_back(int'($urandom_range(16, 26)));
      end else if ($urandom_range(0, 4) == 0) begin
        sp.push_back(int'($urandom_range(1, 6)));
        mk.push_back(int'($urandom_range(1, 3)));
        sp.push_back(int'($urandom_range(1, 8)));
      end else begin
        sp.push_back(int'($urandom_range(1, 15)));
      end
    end
    if (kind == 9) mk[0] = int'($urandom_range(33, 48));
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: every valid/err pulse must match the oldest predicted event.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (key[0] && (bus.valid || bus.err)) begin
        chk("valid_err_exclusive", int'(bus.valid & bus.err), 0);
        chk("event_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("event_is_err", int'(bus.err), int'(e.is_err));
          chk("event_cycle", cyc, e.at);
          if (e.is_err) begin
            chk("letter_held_on_err", int'(bus.letter), int'(mon_letter));
          end else begin
            chk("letter", int'(bus.letter), int'(e.letter));
            chk("ledr_on_valid", int'(bus.LEDR), int'({1'b1, e.letter}));
            mon_letter = e.letter;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    key = 2'b10;
    bus.morse_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_letter", int'(bus.letter), 0);
    chk("reset_valid", int'(bus.valid), 0);
    chk("reset_err", int'(bus.err), 0);
    chk("reset_ledr", int'(bus.LEDR), 0);
    key = 2'b11;
    hold(1'b0, 4);

    // A, then E and H back to back
    mk = '{8, 24};       sp = '{8, 16};       send(1'b0);
    wait_drain();
    chk("v1_ledr", int'(bus.LEDR), 4'b1000);
    mk = '{8};           sp = '{16};          send(1'b0);
    mk = '{8, 8, 8, 8};  sp = '{8, 8, 8, 16}; send(1'b0);
    wait_drain();
    chk("hold_set", int'(bus.LEDR), 4'b1111);
    key[1] = 1'b0;
    @(negedge clk);
    key[1] = 1'b1;
    @(negedge clk);
    chk("ack_clears_hold", int'(bus.LEDR), 4'b0111);

    // "--" is not a letter; then A with a glitch in a space, ack pulsed on the valid cycle
    mk = '{24, 24};      sp = '{8, 16};       send(1'b0);
    mk = '{8, 2, 24};    sp = '{3, 3, 24};    send(1'b1);
    wait_drain();

    // reset in the middle of C's second mark, then D
    hold(1'b1, 24);
    hold(1'b0, 8);
    hold(1'b1, 4);
    key[0] = 1'b0;
    @(negedge clk);
    key[0] = 1'b1;
    mon_letter = 3'd0;
    chk("midreset_letter", int'(bus.letter), 0);
    chk("midreset_ledr", int'(bus.LEDR), 0);
    chk("midreset_pulses", int'({bus.valid, bus.err}), 0);
    hold(1'b0, 24);
    mk = '{24, 8, 8};    sp = '{8, 8, 16};    send(1'b0);
    wait_drain();

    // overlong mark, marks while draining, then E right at the drain boundary
    mk = '{40, 5, 5};    sp = '{2, 2, 16};    send(1'b0);
    mk = '{8};           sp = '{16};          send(1'b0);
    wait_drain();

    for (int n = 0; n < 40; n++) begin
      build_random();
      send(1'b0);
    end
    wait_drain();
    chk("pending_events", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
